// File: rtl/lrf_pkg.sv
// Shared constants and types for the line-rate filter datapath.
// Pixel/beat geometry and the egress wrapper's FSM encoding.
package lrf_pkg;

    localparam int unsigned PIXEL_WIDTH             = 8;
    localparam int unsigned PIXELS_PER_BEAT         = 16;
    localparam int unsigned WORD_WIDTH              = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int unsigned BEATS_PER_FRAME_DEFAULT = 16384;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } egress_state_t;

endpackage

// File: rtl/lrf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: o_data always shows the head entry.
// A push into an empty FIFO becomes visible as the head on the following cycle.
module lrf_sync_fifo
    import lrf_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH + 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop & (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/conv_axis_egress.sv
// Flow-control wrapper downstream of the stall-able convolution core: steps the core,
// tracks beats in flight, buffers results and drives an AXI4-Stream master.
module conv_axis_egress
    import lrf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = WORD_WIDTH,
    parameter int unsigned LATENCY         = 10,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned BEATS_PER_FRAME = BEATS_PER_FRAME_DEFAULT
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  core_en,
    input  logic [DATA_WIDTH-1:0] core_tdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  err_tlast
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

    egress_state_t       r_state;
    egress_state_t       w_state_next;
    logic [LATENCY-1:0]  r_vpipe;
    logic [OCC_W-1:0]    r_occ;
    logic [CNT_W-1:0]    r_in_cnt;
    logic [CNT_W-1:0]    r_out_cnt;
    logic                r_err;
    logic                w_credit_ok;
    logic                w_s_hs;
    logic                w_m_hs;
    logic                w_push;
    logic                w_tag;
    logic [DATA_WIDTH:0] w_head;
    logic                w_empty;
    logic [OCC_W-1:0]    w_fifo_count;

    // occ counts every beat accepted but not yet sent downstream, so the FIFO never overflows.
    assign w_credit_ok = (r_occ < OCC_W'(DEPTH));
    assign w_s_hs      = s_axis_tvalid & s_axis_tready;
    assign w_m_hs      = m_axis_tvalid & m_axis_tready;
    assign w_push      = core_en & r_vpipe[LATENCY-1];
    assign w_tag       = (r_out_cnt == LAST_BEAT);

    always_comb begin
        w_state_next  = r_state;
        s_axis_tready = 1'b0;
        core_en       = 1'b0;
        if (!s_axis_areset) begin
            unique case (r_state)
                IDLE, STREAM: begin
                    s_axis_tready = w_credit_ok;
                    core_en       = s_axis_tvalid & w_credit_ok;
                    if (s_axis_tvalid && w_credit_ok) begin
                        w_state_next = s_axis_tlast ? FLUSH : STREAM;
                    end
                end
                FLUSH: begin
                    core_en = 1'b1;
                    if (r_vpipe == '0) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state   <= IDLE;
            r_vpipe   <= '0;
            r_occ     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (core_en) r_vpipe <= (r_vpipe << 1) | LATENCY'(w_s_hs);
            case ({w_s_hs, w_m_hs})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_s_hs) begin
                r_in_cnt <= (r_in_cnt == LAST_BEAT) ? '0 : r_in_cnt + 1'b1;
                if (s_axis_tlast != (r_in_cnt == LAST_BEAT)) r_err <= 1'b1;
            end
            if (w_push) r_out_cnt <= w_tag ? '0 : r_out_cnt + 1'b1;
        end
    end

    lrf_sync_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk  (s_axis_aclk),
        .i_rst  (s_axis_areset),
        .i_push (w_push),
        .i_data ({w_tag, core_tdata}),
        .i_pop  (w_m_hs),
        .o_data (w_head),
        .o_empty(w_empty),
        .o_count(w_fifo_count)
    );

    a_fifo_within_credit: assert property (@(posedge s_axis_aclk) disable iff (s_axis_areset)
        w_fifo_count <= r_occ);

    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_head[DATA_WIDTH] & ~w_empty;
    assign err_tlast     = r_err;

endmodule
